// File: rtl/axis_pkt_monitor.sv
// AXI-Stream pass-through with per-packet statistics; 1-cycle latency from input handshake to m_axis_tvalid.
// A 2-entry skid buffer absorbs one beat under backpressure, then s_axis_tready (registered) drops until it drains.
module axis_pkt_monitor #(
  parameter int TDATA_WIDTH   = 64,
  parameter int TKEEP_WIDTH   = 64,
  parameter int MAX_PKT_BYTES = 9600,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [TDATA_WIDTH*8-1:0] s_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [TDATA_WIDTH*8-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  input  logic                     stat_clear,
  output logic [CNT_WIDTH-1:0]     pkt_count,
  output logic [CNT_WIDTH-1:0]     byte_count,
  output logic [15:0]              last_pkt_len,
  output logic [CNT_WIDTH-1:0]     oversize_count,
  output logic                     err_oversize,
  output logic                     err_keep
);

  localparam int DW = TDATA_WIDTH * 8;
  localparam int BW = $clog2(TKEEP_WIDTH + 1);
  localparam logic [31:0] MAX_LEN = MAX_PKT_BYTES;

  typedef struct packed {
    logic [DW-1:0]          tdata;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic                   tlast;
  } beat_t;

  typedef enum logic {IDLE, IN_PKT} state_t;

  beat_t in_beat;
  beat_t out_dat_q, out_dat_d;
  beat_t skid_dat_q, skid_dat_d;
  logic  out_vld_q, out_vld_d;
  logic  skid_vld_q, skid_vld_d;
  logic  rdy_q, rdy_d;
  logic  in_hs;

  state_t      state_q, state_d;
  logic [16:0] cur_len_q, cur_len_d;
  logic [BW-1:0] beat_bytes;
  logic [16:0] len_base;
  logic [17:0] len_sum;
  logic [16:0] final_len;

  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0] byte_count_q, byte_count_d;
  logic [CNT_WIDTH-1:0] oversize_count_q, oversize_count_d;
  logic [CNT_WIDTH:0]   byte_sum;
  logic [15:0]          last_pkt_len_q, last_pkt_len_d;
  logic                 err_oversize_q, err_oversize_d;
  logic                 err_keep_q, err_keep_d;

  assign in_beat = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};
  assign in_hs   = s_axis_tvalid && rdy_q;

  // Skid buffer: the skid entry only fills while the output register is stalled,
  // so skid valid implies output valid and tready is simply its inverse.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (!out_vld_q || m_axis_tready) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_hs;
        if (in_hs) begin
          out_dat_d = in_beat;
        end
      end
    end else if (in_hs) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_beat;
    end
    rdy_d = !skid_vld_d;
  end

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < TKEEP_WIDTH; i++) begin
      beat_bytes = beat_bytes + BW'(s_axis_tkeep[i]);
    end
  end

  assign len_base  = (state_q == IN_PKT) ? cur_len_q : 17'd0;
  assign len_sum   = {1'b0, len_base} + 18'(beat_bytes);
  assign final_len = len_sum[17] ? 17'h1FFFF : len_sum[16:0];

  always_comb begin
    state_d   = state_q;
    cur_len_d = cur_len_q;
    if (in_hs) begin
      cur_len_d = final_len;
      state_d   = s_axis_tlast ? IDLE : IN_PKT;
    end
  end

  assign byte_sum = {1'b0, byte_count_q} + (CNT_WIDTH+1)'(beat_bytes);

  // Clear wins over a same-cycle update, dropping that beat's contribution.
  always_comb begin
    pkt_count_d      = pkt_count_q;
    byte_count_d     = byte_count_q;
    oversize_count_d = oversize_count_q;
    last_pkt_len_d   = last_pkt_len_q;
    err_oversize_d   = err_oversize_q;
    err_keep_d       = err_keep_q;
    if (stat_clear) begin
      pkt_count_d      = '0;
      byte_count_d     = '0;
      oversize_count_d = '0;
      last_pkt_len_d   = '0;
      err_oversize_d   = 1'b0;
      err_keep_d       = 1'b0;
    end else if (in_hs) begin
      byte_count_d = byte_sum[CNT_WIDTH] ? '1 : byte_sum[CNT_WIDTH-1:0];
      if (!s_axis_tlast && (s_axis_tkeep != '1)) begin
        err_keep_d = 1'b1;
      end
      if (s_axis_tlast) begin
        if (pkt_count_q != '1) begin
          pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
        end
        last_pkt_len_d = (final_len > 17'h0FFFF) ? 16'hFFFF : final_len[15:0];
        if (32'(final_len) > MAX_LEN) begin
          err_oversize_d = 1'b1;
          if (oversize_count_q != '1) begin
            oversize_count_d = oversize_count_q + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      out_vld_q        <= 1'b0;
      out_dat_q        <= '0;
      skid_vld_q       <= 1'b0;
      skid_dat_q       <= '0;
      rdy_q            <= 1'b0;
      state_q          <= IDLE;
      cur_len_q        <= '0;
      pkt_count_q      <= '0;
      byte_count_q     <= '0;
      oversize_count_q <= '0;
      last_pkt_len_q   <= '0;
      err_oversize_q   <= 1'b0;
      err_keep_q       <= 1'b0;
    end else begin
      out_vld_q        <= out_vld_d;
      out_dat_q        <= out_dat_d;
      skid_vld_q       <= skid_vld_d;
      skid_dat_q       <= skid_dat_d;
      rdy_q            <= rdy_d;
      state_q          <= state_d;
      cur_len_q        <= cur_len_d;
      pkt_count_q      <= pkt_count_d;
      byte_count_q     <= byte_count_d;
      oversize_count_q <= oversize_count_d;
      last_pkt_len_q   <= last_pkt_len_d;
      err_oversize_q   <= err_oversize_d;
      err_keep_q       <= err_keep_d;
    end
  end

  assign s_axis_tready  = rdy_q;
  assign m_axis_tvalid  = out_vld_q;
  assign m_axis_tdata   = out_dat_q.tdata;
  assign m_axis_tkeep   = out_dat_q.tkeep;
  assign m_axis_tlast   = out_dat_q.tlast;
  assign pkt_count      = pkt_count_q;
  assign byte_count     = byte_count_q;
  assign oversize_count = oversize_count_q;
  assign last_pkt_len   = last_pkt_len_q;
  assign err_oversize   = err_oversize_q;
  assign err_keep       = err_keep_q;

endmodule

// File: tb/tb_axis_pkt_monitor.sv
// Directed bench for axis_pkt_monitor: pass-through ordering, backpressure and statistics.
module tb_axis_pkt_monitor;

  localparam int DW = 512;
  localparam int KW = 64;

  logic          clk;
  logic          rst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          stat_clear;
  logic [31:0]   pkt_count;
  logic [31:0]   byte_count;
  logic [15:0]   last_pkt_len;
  logic [31:0]   oversize_count;
  logic          err_oversize;
  logic          err_keep;

  int checks = 0;
  int errors = 0;

  axis_pkt_monitor dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .stat_clear     (stat_clear),
    .pkt_count      (pkt_count),
    .byte_count     (byte_count),
    .last_pkt_len   (last_pkt_len),
    .oversize_count (oversize_count),
    .err_oversize   (err_oversize),
    .err_keep       (err_keep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [31:0] tag, input int idx);
    logic [31:0] w;
    w = tag + 32'(idx);
    return {16{w}};
  endfunction

  task automatic clear_stats();
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
  endtask

  // Sends one packet with m_axis_tready held high and checks each beat appears one cycle later.
  task automatic send_pkt(input int nbeats, input logic [KW-1:0] last_keep, input logic [31:0] tag);
    logic [DW-1:0] pd;
    logic [KW-1:0] pk;
    logic          pl;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      if (b == 0) begin
        check("idle_m_tvalid", m_axis_tvalid, 1'b0);
      end else begin
        check("pass_tvalid", m_axis_tvalid, 1'b1);
        check("pass_tdata", m_axis_tdata, pd);
        check("pass_tkeep", m_axis_tkeep, pk);
        check("pass_tlast", m_axis_tlast, pl);
      end
      check("s_tready_high", s_axis_tready, 1'b1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_data(tag, b);
      s_axis_tkeep  = (b == nbeats - 1) ? last_keep : '1;
      s_axis_tlast  = (b == nbeats - 1);
      pd = s_axis_tdata;
      pk = s_axis_tkeep;
      pl = s_axis_tlast;
    end
    @(negedge clk);
    check("pass_tvalid", m_axis_tvalid, 1'b1);
    check("pass_tdata", m_axis_tdata, pd);
    check("pass_tkeep", m_axis_tkeep, pk);
    check("pass_tlast", m_axis_tlast, pl);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  logic [DW-1:0] exp_q[$];
  int            sent;
  logic          in_fire;
  logic          out_fire;

  initial begin
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    stat_clear    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tdata", m_axis_tdata, '0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_last_len", last_pkt_len, 0);
    check("rst_oversize", oversize_count, 0);
    check("rst_err_flags", {err_oversize, err_keep}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_rst", s_axis_tready, 1'b1);

    // Three 2-beat full packets
    for (int p = 0; p < 3; p++) begin
      send_pkt(2, '1, 32'h1000_0000 + 32'(p * 16));
    end
    check("s1_pkt_count", pkt_count, 3);
    check("s1_byte_count", byte_count, 384);
    check("s1_last_len", last_pkt_len, 128);
    check("s1_err_keep", err_keep, 1'b0);

    // Single-beat 8-byte packet, then a 64-byte one to confirm the FSM stayed IDLE
    clear_stats();
    check("clr_pkt_count", pkt_count, 0);
    send_pkt(1, 64'h0000_0000_0000_00FF, 32'h2000_0000);
    check("s2_pkt_count", pkt_count, 1);
    check("s2_byte_count", byte_count, 8);
    check("s2_last_len", last_pkt_len, 8);
    check("s2_err_keep", err_keep, 1'b0);
    send_pkt(1, '1, 32'h2100_0000);
    check("s2b_pkt_count", pkt_count, 2);
    check("s2b_byte_count", byte_count, 72);
    check("s2b_last_len", last_pkt_len, 64);

    // Continuous input under random backpressure; model tracks beats held inside the DUT
    clear_stats();
    sent = 0;
    for (int it = 0; it < 600 && !(sent == 40 && exp_q.size() == 0); it++) begin
      @(negedge clk);
      check("bp_s_tready", s_axis_tready, exp_q.size() < 2);
      check("bp_m_tvalid", m_axis_tvalid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("bp_m_tdata", m_axis_tdata, exp_q[0]);
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      s_axis_tvalid = (sent < 40);
      s_axis_tdata  = mk_data(32'h3000_0000, sent);
      s_axis_tkeep  = '1;
      s_axis_tlast  = (sent % 4 == 3);
      out_fire = m_axis_tvalid && m_axis_tready;
      in_fire  = s_axis_tvalid && s_axis_tready;
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) begin
        exp_q.push_back(s_axis_tdata);
        sent++;
      end
    end
    check("bp_drained", (sent == 40) && (exp_q.size() == 0), 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("bp_pkt_count", pkt_count, 10);
    check("bp_byte_count", byte_count, 2560);
    check("bp_last_len", last_pkt_len, 256);

    // Oversize boundary: 9600 bytes is legal, 9664 is not
    clear_stats();
    send_pkt(150, '1, 32'h4000_0000);
    check("max_last_len", last_pkt_len, 9600);
    check("max_oversize", oversize_count, 0);
    check("max_err_oversize", err_oversize, 1'b0);
    send_pkt(151, '1, 32'h4100_0000);
    check("ovs_last_len", last_pkt_len, 9664);
    check("ovs_oversize", oversize_count, 1);
    check("ovs_err_oversize", err_oversize, 1'b1);
    check("ovs_byte_count", byte_count, 19264);
    send_pkt(1, '1, 32'h4200_0000);
    check("post_ovs_count", oversize_count, 1);
    check("post_ovs_len", last_pkt_len, 64);
    check("post_ovs_sticky", err_oversize, 1'b1);
    check("post_ovs_pkts", pkt_count, 3);

    // Partial tkeep on a non-last beat
    clear_stats();
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mk_data(32'h5000_0000, 0);
    s_axis_tkeep  = 64'h7FFF_FFFF_FFFF_FFFF;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
    s_axis_tdata  = mk_data(32'h5000_0000, 1);
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("keep_err", err_keep, 1'b1);
    check("keep_bytes", byte_count, 127);
    check("keep_len", last_pkt_len, 127);
    check("keep_pkts", pkt_count, 1);
    send_pkt(1, '1, 32'h5100_0000);
    check("keep_sticky", err_keep, 1'b1);

    // stat_clear coinciding with a tlast beat
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mk_data(32'h5200_0000, 0);
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b1;
    stat_clear    = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    stat_clear    = 1'b0;
    check("clrlast_pkts", pkt_count, 0);
    check("clrlast_bytes", byte_count, 0);
    check("clrlast_len", last_pkt_len, 0);
    check("clrlast_ovs", oversize_count, 0);
    check("clrlast_flags", {err_oversize, err_keep}, 2'b00);

    // Reset mid-packet
    clear_stats();
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mk_data(32'h6000_0000, 0);
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
    s_axis_tdata  = mk_data(32'h6000_0000, 1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    check("mid_bytes", byte_count, 128);
    check("mid_pkts", pkt_count, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_s_tready", s_axis_tready, 1'b0);
    check("mid_rst_bytes", byte_count, 0);
    @(negedge clk);
    check("mid_rst_m_tvalid2", m_axis_tvalid, 1'b0);
    rst_n = 1'b1;
    send_pkt(1, '1, 32'h6100_0000);
    check("post_rst_pkts", pkt_count, 1);
    check("post_rst_bytes", byte_count, 64);
    check("post_rst_len", last_pkt_len, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
